// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Arbitrates CPU and host (loader) requests onto one single-port data memory.
// Each access takes three cycles: arbitrate (IDLE), present address (ACCESS),
// return data and acknowledge the owner (RESP).
// Contested arbitration goes to the CPU. Defining DMEM_ARB_STARVE_EN adds an
// 8-bit host_wait counter, so the host wins one contest after losing
// STARVE_LIMIT contests in a row.
//
// state  | meaning
// IDLE   | no access in flight, arbitrate requests at the next edge
// ACCESS | latched address/data on the memory bus, m_wr follows latched wr
// RESP   | memory data valid, one-cycle ack plus rdata to the owner

module dmem_arbiter #(
    parameter int BUS_WIDTH    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_req,
    input  logic                 c_wr,
    input  logic [BUS_WIDTH-1:0] c_addr,
    input  logic [BUS_WIDTH-1:0] c_wdata,
    output logic                 c_ack,
    output logic [BUS_WIDTH-1:0] c_rdata,
    input  logic                 h_req,
    input  logic                 h_wr,
    input  logic [BUS_WIDTH-1:0] h_addr,
    input  logic [BUS_WIDTH-1:0] h_wdata,
    output logic                 h_ack,
    output logic [BUS_WIDTH-1:0] h_rdata,
    output logic                 m_wr,
    output logic [BUS_WIDTH-1:0] m_addr,
    output logic [BUS_WIDTH-1:0] m_wdata,
    input  logic [BUS_WIDTH-1:0] m_rdata,
    output logic                 busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
            $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
        end
    endgenerate

    logic [1:0] state;
    logic       wr_q;
    logic       owner;       // 0 = CPU, 1 = host
    logic       grant_host;

`ifdef DMEM_ARB_STARVE_EN
    logic [7:0] host_wait;

    // Host wins when alone, or in a contest once it has waited STARVE_LIMIT times
    always_comb begin
        grant_host = h_req && (!c_req || (host_wait == 8'(STARVE_LIMIT)));
    end

    // Count contested arbitrations lost by the host; any host grant clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            host_wait <= 8'd0;
        end else if (state == IDLE && (c_req || h_req)) begin
            if (grant_host) begin
                host_wait <= 8'd0;
            end else if (h_req) begin
                host_wait <= host_wait + 8'd1;
            end
        end
    end
`else
    // Strict CPU priority: host wins only when the CPU is not requesting
    always_comb begin
        grant_host = h_req && !c_req;
    end
`endif

    // Sequencer and request latch; reset drops any in-flight access without ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            owner   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (c_req || h_req) begin
                        state   <= ACCESS;
                        owner   <= grant_host;
                        wr_q    <= grant_host ? h_wr    : c_wr;
                        m_addr  <= grant_host ? h_addr  : c_addr;
                        m_wdata <= grant_host ? h_wdata : c_wdata;
                    end
                end
                ACCESS:  state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Decode memory strobe, acks and gated read data from the current state
    always_comb begin
        busy    = (state != IDLE);
        m_wr    = (state == ACCESS) && wr_q;
        c_ack   = (state == RESP) && !owner;
        h_ack   = (state == RESP) && owner;
        c_rdata = c_ack ? m_rdata : '0;
        h_rdata = h_ack ? m_rdata : '0;
    end

endmodule
